// File: rtl/spi_target_rx.sv
// spi_target_rx: SPI mode-0 receiver that deserialises {dc, byte} into a FIFO read over an OBI-style register port
module spi_target_rx #(
    parameter int DEPTH         = 8,
    parameter bit CS_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        sck_i,
    input  logic        mosi_i,
    input  logic        cs_i,
    input  logic        dc_i,
    output logic        irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    s1_q, s2_q;
    logic          sck_h_q;
    logic [6:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          push_q;
    logic [8:0]    push_data_q;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q, frame_q;
    logic [1:0]    ctrl_q;
    logic          rvalid_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          sck_s, mosi_s, cs_s, dc_s, cs_act, sck_rise, en;
    logic          rd_en, wr_en, clr, pop, full, empty, do_push, ovf_set, frame_set, last_bit;
    logic [1:0]    sel;
    logic [31:0]   rx_word, status;
    logic          unused_ok;

    assign {dc_s, cs_s, mosi_s, sck_s} = s2_q;
    assign cs_act    = CS_ACTIVE_LOW ? ~cs_s : cs_s;
    assign sck_rise  = sck_s & ~sck_h_q;
    assign en        = ctrl_q[0];
    assign last_bit  = cs_act & en & sck_rise & (bit_cnt_q == 3'd7);
    assign sel       = addr_i[3:2];
    assign rd_en     = req_i & ~we_i;
    assign wr_en     = req_i & we_i;
    assign clr       = wr_en & (sel == 2'd0) & wdata_i[2];
    assign empty     = cnt_q == '0;
    assign full      = cnt_q == CW'(DEPTH);
    assign pop       = rd_en & (sel == 2'd1) & ~empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push   = push_q & (~full | pop);
    assign ovf_set   = push_q & full & ~pop;
    assign frame_set = ~cs_act & (bit_cnt_q != 3'd0);
    assign rx_word   = empty ? '0 : {23'b0, mem_q[rd_q]};
    assign status    = {16'b0, 8'(cnt_q), 4'b0, frame_q, ovf_q, full, empty};
    assign gnt_o     = req_i;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign irq_o     = ~empty & ctrl_q[1];
    assign unused_ok = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:3]};

    always_comb begin
        rdata_d = !rd_en       ? '0 :
                  sel == 2'd0  ? {30'b0, ctrl_q} :
                  sel == 2'd1  ? rx_word :
                  sel == 2'd2  ? status : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q        <= '0;
            s2_q        <= '0;
            sck_h_q     <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            s1_q        <= {dc_i, cs_i, mosi_i, sck_i};
            s2_q        <= s1_q;
            sck_h_q     <= sck_s;
            push_q      <= last_bit;
            if (last_bit)
                push_data_q <= {dc_s, shift_q, mosi_s};
            if (!cs_act || !en)
                bit_cnt_q <= '0;
            else if (sck_rise) begin
                shift_q   <= {shift_q[5:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr)
            mem_q[wr_q] <= push_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            frame_q  <= 1'b0;
            ctrl_q   <= 2'b01;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            rdata_q  <= rdata_d;
            if (wr_en && sel == 2'd0)
                ctrl_q <= wdata_i[1:0];
            if (clr) begin
                wr_q    <= '0;
                rd_q    <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
                frame_q <= 1'b0;
            end else begin
                wr_q    <= wr_q + AW'(do_push);
                rd_q    <= rd_q + AW'(pop);
                cnt_q   <= cnt_q + CW'(do_push) - CW'(pop);
                ovf_q   <= ovf_q | ovf_set;
                frame_q <= frame_q | frame_set;
            end
        end
    end
endmodule

// File: tb/tb_spi_target_rx.sv
// tb_spi_target_rx: directed scenario tests for spi_target_rx with DEPTH=4
module tb_spi_target_rx;
    logic        clk, rst_n, req, we, gnt, rvalid, sck, mosi, cs, dc, irq;
    logic [31:0] addr, wdata, rdata;
    int checks = 0, failures = 0;

    spi_target_rx #(.DEPTH(4), .CS_ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .wdata_i(wdata),
        .we_i(we), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .sck_i(sck), .mosi_i(mosi), .cs_i(cs), .dc_i(dc), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd;
        #1;
        checks++;
        if (gnt !== 1'b1) begin failures++; $display("FAIL gnt addr=%h got=%b exp=1", a, gnt); end
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin failures++; $display("FAIL rvalid addr=%h got=%b exp=1", a, rvalid); end
        rd = rdata;
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_on;
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rst_n = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; sck = 0; mosi = 0; cs = 1; dc = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rvalid, rdata, irq, gnt} !== 35'b0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {rvalid, rdata, irq, gnt}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
        bus(0, 32'h0, 0, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", v, 32'h1); end
        bus(1, 32'hC, 32'hFFFF_FFFF, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_write_rdata got=%h exp=0", v); end
        bus(0, 32'hC, 0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", v); end
    endtask

    task automatic test_control_bytes;
        logic [31:0] v;
        dc = 1'b0;
        cs_on();
        spi_byte(8'h00);
        spi_byte(8'hAF);
        cs_off();
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0200) begin failures++; $display("FAIL ctl_status got=%h exp=%h", v, 32'h0200); end
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h000) begin failures++; $display("FAIL ctl_rx0 got=%h exp=%h", v, 32'h000); end
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h0AF) begin failures++; $display("FAIL ctl_rx1 got=%h exp=%h", v, 32'h0AF); end
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0001) begin failures++; $display("FAIL ctl_empty got=%h exp=%h", v, 32'h0001); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL ctl_irq got=%b exp=0", irq); end
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL pop_empty got=%h exp=0", v); end
    endtask

    task automatic test_data_byte;
        logic [31:0] v;
        logic [7:0]  b;
        b = 8'hA5;
        bus(1, 32'h0, 32'h3, v);
        dc = 1'b1;
        cs_on();
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        mosi = b[0];
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL data_irq_early got=%b exp=0", irq); end
        sck = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL data_irq_latency got=%b exp=1", irq); end
        repeat (4) @(negedge clk);
        sck = 1'b0;
        cs_off();
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h1A5) begin failures++; $display("FAIL data_rx got=%h exp=%h", v, 32'h1A5); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL data_irq_after_pop got=%b exp=0", irq); end
    endtask

    task automatic test_overflow;
        logic [31:0] v;
        dc = 1'b0;
        cs_on();
        for (int i = 1; i <= 5; i++) spi_byte(8'(i));
        cs_off();
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0406) begin failures++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h0406); end
        for (int i = 1; i <= 4; i++) begin
            bus(0, 32'h4, 0, v);
            checks++;
            if (v !== 32'(i)) begin failures++; $display("FAIL ovf_rx%0d got=%h exp=%h", i, v, 32'(i)); end
        end
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0005) begin failures++; $display("FAIL ovf_sticky got=%h exp=%h", v, 32'h0005); end
        bus(1, 32'h0, 32'h5, v);
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0001) begin failures++; $display("FAIL ovf_clr got=%h exp=%h", v, 32'h0001); end
        bus(0, 32'h0, 0, v);
        checks++;
        if (v !== 32'h1) begin failures++; $display("FAIL ctrl_clr_reads0 got=%h exp=%h", v, 32'h1); end
    endtask

    task automatic test_frame_error;
        logic [31:0] v;
        dc = 1'b0;
        cs_on();
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        cs_off();
        cs_on();
        spi_byte(8'h3C);
        cs_off();
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0108) begin failures++; $display("FAIL frame_status got=%h exp=%h", v, 32'h0108); end
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h03C) begin failures++; $display("FAIL frame_rx got=%h exp=%h", v, 32'h03C); end
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0009) begin failures++; $display("FAIL frame_only_one got=%h exp=%h", v, 32'h0009); end
        bus(1, 32'h0, 32'h5, v);
    endtask

    task automatic test_simultaneous;
        logic [31:0] v;
        logic [7:0]  b;
        b = 8'h14;
        dc = 1'b0;
        cs_on();
        for (int i = 0; i < 4; i++) spi_byte(8'h10 + 8'(i));
        for (int i = 7; i >= 1; i--) spi_bit(b[i]);
        mosi = b[0];
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(posedge clk);
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h010) begin failures++; $display("FAIL sim_head got=%h exp=%h", v, 32'h010); end
        sck = 1'b0;
        cs_off();
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0402) begin failures++; $display("FAIL sim_status got=%h exp=%h", v, 32'h0402); end
        for (int i = 1; i <= 4; i++) begin
            bus(0, 32'h4, 0, v);
            checks++;
            if (v !== 32'h10 + 32'(i)) begin failures++; $display("FAIL sim_rx%0d got=%h exp=%h", i, v, 32'h10 + 32'(i)); end
        end
    endtask

    task automatic test_reset_mid_byte;
        logic [31:0] v;
        dc = 1'b0;
        cs_on();
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cs = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        cs_on();
        spi_byte(8'h81);
        cs_off();
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0100) begin failures++; $display("FAIL rst_status got=%h exp=%h", v, 32'h0100); end
        bus(0, 32'h4, 0, v);
        checks++;
        if (v !== 32'h081) begin failures++; $display("FAIL rst_rx got=%h exp=%h", v, 32'h081); end
        bus(0, 32'h8, 0, v);
        checks++;
        if (v !== 32'h0001) begin failures++; $display("FAIL rst_empty got=%h exp=%h", v, 32'h0001); end
    endtask

    initial begin
        test_reset();
        test_control_bytes();
        test_data_byte();
        test_overflow();
        test_frame_error();
        test_simultaneous();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
